// File: rtl/mesi_isc_pkg.sv
`default_nettype none
//==============================================================================
// Module      : mesi_isc_pkg
// Description : Shared definitions for the MESI inter-cache broadcast arbiter:
//               master count, mbus/cbus command encodings, FSM state type.
// Revision    : 1.0 - initial release
//==============================================================================
package mesi_isc_pkg;

  localparam int c_NUM_MASTERS = 4;
  localparam int c_PTR_W       = 2;

  // mbus (master -> arbiter) request commands; any other code behaves as NOP
  localparam int unsigned c_MBUS_NOP      = 0;
  localparam int unsigned c_MBUS_WR_BROAD = 3;
  localparam int unsigned c_MBUS_RD_BROAD = 4;

  // cbus (arbiter -> cache) snoop / enable commands
  localparam int unsigned c_CBUS_NOP      = 0;
  localparam int unsigned c_CBUS_WR_SNOOP = 1;
  localparam int unsigned c_CBUS_RD_SNOOP = 2;
  localparam int unsigned c_CBUS_EN_WR    = 3;
  localparam int unsigned c_CBUS_EN_RD    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SNOOP  = 2'd1,
    ST_ENABLE = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mesi_isc_rr_arb.sv
`default_nettype none
//==============================================================================
// Module      : mesi_isc_rr_arb
// Description : Purely combinational 4-way round-robin selector. The search
//               starts at ptr and wraps; the first active request wins.
// Ports       : req - per-master request flags
//               ptr - index holding highest priority this cycle
//               gnt - one-hot grant (all zero when no request)
// Revision    : 1.0 - initial release
//==============================================================================
module mesi_isc_rr_arb
  import mesi_isc_pkg::*;
(
  input  logic [c_NUM_MASTERS-1:0] req,
  input  logic [c_PTR_W-1:0]       ptr,
  output logic [c_NUM_MASTERS-1:0] gnt
);

  logic [c_PTR_W-1:0] w_idx;
  logic               w_found;

  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < c_NUM_MASTERS; k++) begin
      // index arithmetic wraps naturally at the 2-bit width
      w_idx = ptr + c_PTR_W'(k);
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mesi_isc_bcast_arb.sv
`default_nettype none
//==============================================================================
// Module      : mesi_isc_bcast_arb
// Description : Broadcast arbiter. Grants one master at a time (round-robin),
//               snoops the other three caches, enables the requester's cache,
//               then returns a one-cycle completion pulse to the master.
// Ports       : clk, rst (sync, active low)
//               mbus_cmdN_i / mbus_addrN_i - per-master request
//               cbus_ackN_i                - per-cache acknowledge pulse
//               cbus_addr_o                - address of granted transaction
//               cbus_cmdN_o                - per-cache snoop / enable command
//               mbus_ackN_o                - per-master completion pulse
//               busy_o                     - FSM not idle
// Revision    : 1.0 - initial release
//==============================================================================
module mesi_isc_bcast_arb
  import mesi_isc_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int CMD_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CMD_WIDTH-1:0]  mbus_cmd3_i,
  input  logic [CMD_WIDTH-1:0]  mbus_cmd2_i,
  input  logic [CMD_WIDTH-1:0]  mbus_cmd1_i,
  input  logic [CMD_WIDTH-1:0]  mbus_cmd0_i,
  input  logic [ADDR_WIDTH-1:0] mbus_addr3_i,
  input  logic [ADDR_WIDTH-1:0] mbus_addr2_i,
  input  logic [ADDR_WIDTH-1:0] mbus_addr1_i,
  input  logic [ADDR_WIDTH-1:0] mbus_addr0_i,
  input  logic                  cbus_ack3_i,
  input  logic                  cbus_ack2_i,
  input  logic                  cbus_ack1_i,
  input  logic                  cbus_ack0_i,
  output logic [ADDR_WIDTH-1:0] cbus_addr_o,
  output logic [CMD_WIDTH-1:0]  cbus_cmd3_o,
  output logic [CMD_WIDTH-1:0]  cbus_cmd2_o,
  output logic [CMD_WIDTH-1:0]  cbus_cmd1_o,
  output logic [CMD_WIDTH-1:0]  cbus_cmd0_o,
  output logic                  mbus_ack3_o,
  output logic                  mbus_ack2_o,
  output logic                  mbus_ack1_o,
  output logic                  mbus_ack0_o,
  output logic                  busy_o
);

  logic [CMD_WIDTH-1:0]     w_mbus_cmd  [c_NUM_MASTERS];
  logic [ADDR_WIDTH-1:0]    w_mbus_addr [c_NUM_MASTERS];
  logic [CMD_WIDTH-1:0]     w_cbus_cmd  [c_NUM_MASTERS];
  logic [c_NUM_MASTERS-1:0] w_cbus_ack;
  logic [c_NUM_MASTERS-1:0] w_mbus_ack;
  logic [ADDR_WIDTH-1:0]    w_cbus_addr;
  logic [c_NUM_MASTERS-1:0] w_req;
  logic [c_NUM_MASTERS-1:0] w_gnt;
  logic [c_PTR_W-1:0]       w_gnt_id;
  logic [c_NUM_MASTERS-1:0] w_req_oh;
  logic [c_NUM_MASTERS-1:0] w_new_ack;
  logic                     w_snoop_done;

  arb_state_t               r_state;
  arb_state_t               w_state_nxt;
  logic [c_PTR_W-1:0]       r_ptr;
  logic [c_PTR_W-1:0]       r_req_id;
  logic                     r_is_wr;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [c_NUM_MASTERS-1:0] r_ack_mask;

  assign w_mbus_cmd  = '{mbus_cmd0_i, mbus_cmd1_i, mbus_cmd2_i, mbus_cmd3_i};
  assign w_mbus_addr = '{mbus_addr0_i, mbus_addr1_i, mbus_addr2_i, mbus_addr3_i};
  assign w_cbus_ack  = {cbus_ack3_i, cbus_ack2_i, cbus_ack1_i, cbus_ack0_i};

  // Only the two broadcast codes are requests; every other code is a NOP.
  always_comb begin
    w_req = '0;
    for (int i = 0; i < c_NUM_MASTERS; i++) begin
      w_req[i] = (w_mbus_cmd[i] == CMD_WIDTH'(c_MBUS_WR_BROAD)) ||
                 (w_mbus_cmd[i] == CMD_WIDTH'(c_MBUS_RD_BROAD));
    end
  end

  mesi_isc_rr_arb u_rr_arb (
    .req (w_req),
    .ptr (r_ptr),
    .gnt (w_gnt)
  );

  always_comb begin
    w_gnt_id = '0;
    for (int i = 0; i < c_NUM_MASTERS; i++) begin
      if (w_gnt[i]) w_gnt_id = c_PTR_W'(i);
    end
  end

  assign w_req_oh  = c_NUM_MASTERS'(1) << r_req_id;
  // Acks from the requester or from already-acked caches carry no information.
  assign w_new_ack = w_cbus_ack & ~r_ack_mask & ~w_req_oh;
  // Counting the requester as covered lets a same-cycle last ack close SNOOP.
  assign w_snoop_done = &(r_ack_mask | w_new_ack | w_req_oh);

  always_comb begin
    w_state_nxt = r_state;
    w_mbus_ack  = '0;
    w_cbus_addr = '0;
    for (int i = 0; i < c_NUM_MASTERS; i++) w_cbus_cmd[i] = CMD_WIDTH'(c_CBUS_NOP);
    case (r_state)
      ST_IDLE: begin
        if (|w_req) w_state_nxt = ST_SNOOP;
      end
      ST_SNOOP: begin
        w_cbus_addr = r_addr;
        for (int i = 0; i < c_NUM_MASTERS; i++) begin
          if (!w_req_oh[i] && !r_ack_mask[i]) begin
            w_cbus_cmd[i] = r_is_wr ? CMD_WIDTH'(c_CBUS_WR_SNOOP) : CMD_WIDTH'(c_CBUS_RD_SNOOP);
          end
        end
        if (w_snoop_done) w_state_nxt = ST_ENABLE;
      end
      ST_ENABLE: begin
        w_cbus_addr          = r_addr;
        w_cbus_cmd[r_req_id] = r_is_wr ? CMD_WIDTH'(c_CBUS_EN_WR) : CMD_WIDTH'(c_CBUS_EN_RD);
        if (w_cbus_ack[r_req_id]) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        w_cbus_addr          = r_addr;
        w_mbus_ack[r_req_id] = 1'b1;
        w_state_nxt          = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_req_id   <= '0;
      r_is_wr    <= 1'b0;
      r_addr     <= '0;
      r_ack_mask <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && |w_req) begin
        r_req_id   <= w_gnt_id;
        r_ptr      <= w_gnt_id + c_PTR_W'(1);
        r_is_wr    <= (w_mbus_cmd[w_gnt_id] == CMD_WIDTH'(c_MBUS_WR_BROAD));
        r_addr     <= w_mbus_addr[w_gnt_id];
        r_ack_mask <= '0;
      end else if (r_state == ST_SNOOP) begin
        r_ack_mask <= r_ack_mask | w_new_ack;
      end
    end
  end

  assign cbus_addr_o = w_cbus_addr;
  assign cbus_cmd0_o = w_cbus_cmd[0];
  assign cbus_cmd1_o = w_cbus_cmd[1];
  assign cbus_cmd2_o = w_cbus_cmd[2];
  assign cbus_cmd3_o = w_cbus_cmd[3];
  assign mbus_ack0_o = w_mbus_ack[0];
  assign mbus_ack1_o = w_mbus_ack[1];
  assign mbus_ack2_o = w_mbus_ack[2];
  assign mbus_ack3_o = w_mbus_ack[3];
  assign busy_o      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mesi_isc_bcast_arb.sv
`default_nettype none
//==============================================================================
// Module      : tb_mesi_isc_bcast_arb
// Description : Scoreboard bench for mesi_isc_bcast_arb. Stimulus pushes the
//               expected output vector of every busy cycle; a negedge monitor
//               pops and compares on busy cycles and requires all-zero outputs
//               on idle cycles.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_mesi_isc_bcast_arb;

  localparam logic [2:0] c_M_WR = 3'd3;
  localparam logic [2:0] c_M_RD = 3'd4;
  localparam logic [2:0] c_C_WS = 3'd1;
  localparam logic [2:0] c_C_RS = 3'd2;
  localparam logic [2:0] c_C_EW = 3'd3;
  localparam logic [2:0] c_C_ER = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  m_cmd  [4];
  logic [31:0] m_addr [4];
  logic [3:0]  c_ack;
  logic [31:0] cbus_addr;
  logic [2:0]  cbus_cmd0, cbus_cmd1, cbus_cmd2, cbus_cmd3;
  logic        mack0, mack1, mack2, mack3;
  logic        busy;

  // {cmd3, cmd2, cmd1, cmd0, addr, mack3..0}
  logic [47:0] exp_q [$];
  string       name_q [$];
  int          vectors = 0;
  int          errs    = 0;
  bit          mon_en  = 1'b0;
  int          plan [4];
  logic [3:0]  xack [8];

  always #5 clk = ~clk;

  mesi_isc_bcast_arb dut (
    .clk          (clk),
    .rst          (rst),
    .mbus_cmd3_i  (m_cmd[3]),
    .mbus_cmd2_i  (m_cmd[2]),
    .mbus_cmd1_i  (m_cmd[1]),
    .mbus_cmd0_i  (m_cmd[0]),
    .mbus_addr3_i (m_addr[3]),
    .mbus_addr2_i (m_addr[2]),
    .mbus_addr1_i (m_addr[1]),
    .mbus_addr0_i (m_addr[0]),
    .cbus_ack3_i  (c_ack[3]),
    .cbus_ack2_i  (c_ack[2]),
    .cbus_ack1_i  (c_ack[1]),
    .cbus_ack0_i  (c_ack[0]),
    .cbus_addr_o  (cbus_addr),
    .cbus_cmd3_o  (cbus_cmd3),
    .cbus_cmd2_o  (cbus_cmd2),
    .cbus_cmd1_o  (cbus_cmd1),
    .cbus_cmd0_o  (cbus_cmd0),
    .mbus_ack3_o  (mack3),
    .mbus_ack2_o  (mack2),
    .mbus_ack1_o  (mack1),
    .mbus_ack0_o  (mack0),
    .busy_o       (busy)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] cmds, input logic [31:0] a,
                      input logic [3:0] mk, input string n);
    exp_q.push_back({cmds, a, mk});
    name_q.push_back(n);
  endtask

  task automatic set_plan(input int p0, input int p1, input int p2, input int p3);
    plan[0] = p0; plan[1] = p1; plan[2] = p2; plan[3] = p3;
    for (int k = 0; k < 8; k++) xack[k] = 4'b0000;
  endtask

  // Called in the IDLE cycle where master m's request is already presented.
  // plan[j] = snoop cycle in which cache j acks; xack[k] = extra (ignored) acks.
  task automatic txn(input int m, input bit wr, input logic [31:0] a,
                     input int en_wait, input bit drop, input string tag);
    int         last;
    logic [11:0] cmds;
    logic [3:0]  ack;
    last = 0;
    for (int j = 0; j < 4; j++) if (j != m && plan[j] > last) last = plan[j];
    cyc();
    for (int k = 0; k <= last; k++) begin
      cmds = '0;
      ack  = xack[k];
      for (int j = 0; j < 4; j++) begin
        if (j != m) begin
          if (plan[j] >= k) cmds[3*j +: 3] = wr ? c_C_WS : c_C_RS;
          if (plan[j] == k) ack[j] = 1'b1;
        end
      end
      push(cmds, a, 4'b0000, $sformatf("%s_snoop%0d", tag, k));
      c_ack = ack;
      cyc();
    end
    c_ack = 4'b0000;
    for (int e = 0; e <= en_wait; e++) begin
      cmds = '0;
      cmds[3*m +: 3] = wr ? c_C_EW : c_C_ER;
      push(cmds, a, 4'b0000, $sformatf("%s_enable%0d", tag, e));
      c_ack = (e == en_wait) ? (4'b0001 << m) : 4'b0000;
      cyc();
    end
    c_ack = 4'b0000;
    push(12'h000, a, 4'b0001 << m, $sformatf("%s_resp", tag));
    cyc();
    if (drop) m_cmd[m] = 3'd0;
  endtask

  // Monitor: decoupled from stimulus, samples mid-cycle.
  initial begin
    logic [47:0] act;
    logic [47:0] e;
    string       n;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        act = {cbus_cmd3, cbus_cmd2, cbus_cmd1, cbus_cmd0, cbus_addr,
               mack3, mack2, mack1, mack0};
        vectors++;
        if (busy === 1'b1) begin
          if (exp_q.size() == 0) begin
            errs++;
            $display("FAIL unexpected_busy: got %h, required idle", act);
          end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (act !== e) begin
              errs++;
              $display("FAIL %s: got %h, required %h", n, act, e);
            end
          end
        end else if (act !== 48'h0) begin
          errs++;
          $display("FAIL idle_outputs: got %h busy %b, required 0", act, busy);
        end
      end
    end
  end

  initial begin
    rst   = 1'b0;
    c_ack = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      m_cmd[i]  = 3'd0;
      m_addr[i] = 32'h0;
    end
    set_plan(0, 0, 0, 0);
    repeat (3) cyc();
    mon_en = 1'b1;
    cyc();
    rst = 1'b1;

    // Master 1 read; caches 0,2,3 ack one cycle after snoop, cache 1 acks enable.
    m_cmd[1] = c_M_RD; m_addr[1] = 32'h100;
    set_plan(1, 0, 1, 1);
    txn(1, 1'b0, 32'h100, 0, 1'b0, "rd_m1");

    // Master 1 keeps requesting, master 2 joins: ptr=2 so master 2 first.
    m_cmd[2] = c_M_RD; m_addr[2] = 32'h300;
    set_plan(0, 0, 0, 0);
    txn(2, 1'b0, 32'h300, 0, 1'b1, "rr_m2");
    txn(1, 1'b0, 32'h100, 0, 1'b1, "rr_m1");

    // Minimum latency write from master 0; ptr 2 -> 0, leaves ptr=1.
    m_cmd[0] = c_M_WR; m_addr[0] = 32'h200;
    txn(0, 1'b1, 32'h200, 0, 1'b1, "minlat_m0");

    // Masters 0 and 2 together at ptr=1: 2 then 0.
    m_cmd[0] = c_M_WR; m_addr[0] = 32'h400;
    m_cmd[2] = c_M_RD; m_addr[2] = 32'h500;
    txn(2, 1'b0, 32'h500, 0, 1'b1, "pair_m2");
    txn(0, 1'b1, 32'h400, 0, 1'b1, "pair_m0");

    // Staggered snoop acks 3,1,0 for requester 2; slow enable ack.
    m_cmd[2] = c_M_RD; m_addr[2] = 32'h600;
    set_plan(2, 1, 0, 0);
    txn(2, 1'b0, 32'h600, 2, 1'b1, "stagger_m2");

    // Requester 3: duplicate ack from cache 2 and stray acks from cache 3.
    m_cmd[3] = c_M_WR; m_addr[3] = 32'h700;
    set_plan(2, 3, 0, 0);
    xack[1] = 4'b1100;
    xack[2] = 4'b1000;
    txn(3, 1'b1, 32'h700, 0, 1'b1, "dup_m3");

    // Reset in ENABLE: abort without mbus_ack, then re-grant the held request.
    m_cmd[0] = c_M_RD; m_addr[0] = 32'h800;
    set_plan(0, 0, 0, 0);
    cyc();
    push({c_C_RS, c_C_RS, c_C_RS, 3'd0}, 32'h800, 4'b0000, "abort_snoop");
    c_ack = 4'b1110;
    cyc();
    push({3'd0, 3'd0, 3'd0, c_C_ER}, 32'h800, 4'b0000, "abort_enable");
    c_ack = 4'b0001;
    rst   = 1'b0;
    cyc();
    c_ack = 4'b0000;
    cyc();
    rst = 1'b1;
    txn(0, 1'b0, 32'h800, 0, 1'b1, "regrant_m0");

    // Reset to ptr=0, then all four masters hold WR_BROAD for 8 transactions.
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_cmd[i]  = c_M_WR;
      m_addr[i] = 32'h1000 + 32'(16 * i);
    end
    for (int n = 0; n < 8; n++) begin
      txn(n % 4, 1'b1, 32'h1000 + 32'(16 * (n % 4)), 0, 1'b0,
          $sformatf("allwr%0d_m%0d", n, n % 4));
    end
    for (int i = 0; i < 4; i++) m_cmd[i] = 3'd0;
    repeat (4) cyc();

    vectors++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL leftover_expect: %0d records unconsumed, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
`default_nettype wire
